// File: rtl/servo_pwm_scheduler.sv
// rtl/servo_pwm_scheduler.sv - multi-channel servo PWM scheduler with staggered slots
// Widths are staged in shadow registers and copied to the active set only when a frame starts.
module servo_pwm_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int FRAME_TICKS  = 4000,
  parameter int SLOT_TICKS   = 500,
  parameter int MIN_TICKS    = 200,
  parameter int MAX_TICKS    = 400,
  parameter int CENTER_TICKS = 300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [9:0]        cfg_width,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              running
);

  if (NUM_CH < 1 || NUM_CH > 8 || FRAME_TICKS > 4096 || MAX_TICKS > 1023 ||
      MIN_TICKS > MAX_TICKS ||
      (NUM_CH - 1) * SLOT_TICKS + MAX_TICKS > FRAME_TICKS) begin : g_bad_params
    $error("servo_pwm_scheduler: illegal parameter combination");
  end

  localparam logic [11:0] LAST_CNT = 12'(FRAME_TICKS - 1);
  localparam logic [9:0]  MIN_W    = 10'(MIN_TICKS);
  localparam logic [9:0]  MAX_W    = 10'(MAX_TICKS);
  localparam logic [9:0]  CENTER_W = 10'(CENTER_TICKS);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q;
  logic [11:0]        frame_cnt_q;
  logic [9:0]         shadow_q [NUM_CH];
  logic [9:0]         active_q [NUM_CH];
  logic [NUM_CH-1:0]  pwm_q;
  logic               frame_start_q;
  logic               cfg_err_q;
  logic               running_q;

  logic               last_cnt;
  logic               start_frame;
  logic               cfg_fire;
  logic               cfg_ch_ok;
  logic [9:0]         width_d;
  logic [11:0]        cnt_d;
  logic [NUM_CH-1:0]  pwm_d;

  assign last_cnt    = (frame_cnt_q == LAST_CNT);
  // A transfer cycle is a tick that begins a new frame; writes stall so the copy sees a stable shadow.
  assign start_frame = tick && enable && ((state_q == S_IDLE) || last_cnt);
  assign cfg_ready   = !start_frame;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign cfg_ch_ok   = ({1'b0, cfg_ch} < 4'(NUM_CH));

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign cfg_err     = cfg_err_q;
  assign running     = running_q;

  always_comb begin
    width_d = cfg_width;
    if (cfg_width < MIN_W) begin
      width_d = MIN_W;
    end else if (cfg_width > MAX_W) begin
      width_d = MAX_W;
    end
  end

  // Pulse pattern for the count being loaded on this tick; a new frame uses the shadow widths.
  always_comb begin
    logic [12:0] lo;
    logic [12:0] hi;
    logic [9:0]  w;
    cnt_d = (start_frame || last_cnt) ? 12'd0 : 12'(frame_cnt_q + 12'd1);
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w  = start_frame ? shadow_q[i] : active_q[i];
      lo = 13'(i * SLOT_TICKS);
      hi = lo + {3'b000, w};
      pwm_d[i] = ({1'b0, cnt_d} >= lo) && ({1'b0, cnt_d} < hi);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= '0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      running_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= CENTER_W;
        active_q[i] <= CENTER_W;
      end
    end else begin
      frame_start_q <= 1'b0;
      cfg_err_q     <= cfg_fire && !cfg_ch_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_fire && cfg_ch == 3'(i)) begin
          shadow_q[i] <= width_d;
        end
      end
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (enable) begin
              state_q       <= S_RUN;
              running_q     <= 1'b1;
              frame_cnt_q   <= '0;
              active_q      <= shadow_q;
              pwm_q         <= pwm_d;
              frame_start_q <= 1'b1;
            end
          end
          S_RUN: begin
            frame_cnt_q <= cnt_d;
            if (start_frame) begin
              active_q      <= shadow_q;
              pwm_q         <= pwm_d;
              frame_start_q <= 1'b1;
            end else if (last_cnt) begin
              state_q   <= S_IDLE;
              running_q <= 1'b0;
              pwm_q     <= '0;
            end else begin
              pwm_q <= pwm_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// tb/tb_servo_pwm_scheduler.sv - self-checking bench for servo_pwm_scheduler
module tb_servo_pwm_scheduler;

  localparam int NCH   = 4;
  localparam int FRAME = 4000;
  localparam int SLOT  = 500;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           tick = 1'b0;
  logic           enable = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [2:0]     cfg_ch = 3'd0;
  logic [9:0]     cfg_width = 10'd0;
  logic           cfg_err;
  logic [NCH-1:0] pwm_out;
  logic           frame_start;
  logic           running;

  servo_pwm_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_width(cfg_width), .cfg_err(cfg_err), .pwm_out(pwm_out),
    .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int drv_cnt = 0;

  // Model: frame position, widths latched at each frame start, pending shadow widths.
  int       m_shadow [NCH];
  int       m_active [NCH];
  bit       m_run = 1'b0;
  int       m_pos = 0;
  bit       m_valid = 1'b0;
  bit       e_fs = 1'b0;
  bit       e_err = 1'b0;
  bit       m_fire;

  function automatic int clamp(int w);
    if (w < 200) return 200;
    if (w > 400) return 400;
    return w;
  endfunction

  function automatic bit model_ready();
    return !(tick && enable && (!m_run || m_pos == FRAME - 1));
  endfunction

  function automatic logic [NCH-1:0] model_pwm();
    logic [NCH-1:0] p = '0;
    for (int c = 0; c < NCH; c++)
      p[c] = m_run && (m_pos >= c * SLOT) && (m_pos < c * SLOT + m_active[c]);
    return p;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_valid = 1'b1;
      m_run = 1'b0;
      m_pos = 0;
      e_fs = 1'b0;
      e_err = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_shadow[c] = 300;
        m_active[c] = 300;
      end
    end else begin
      m_fire = cfg_valid && model_ready();
      e_err = m_fire && (cfg_ch >= NCH);
      e_fs = 1'b0;
      if (tick) begin
        if (!m_run) begin
          if (enable) begin
            m_run = 1'b1;
            m_pos = 0;
            m_active = m_shadow;
            e_fs = 1'b1;
          end
        end else if (m_pos == FRAME - 1) begin
          m_pos = 0;
          if (enable) begin
            m_active = m_shadow;
            e_fs = 1'b1;
          end else begin
            m_run = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end
      if (m_fire && cfg_ch < NCH) m_shadow[cfg_ch] = clamp(int'(cfg_width));
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks += 5;
      if (pwm_out !== model_pwm()) begin
        failures++;
        $display("FAIL cyc_pwm t=%0t got %b expected %b", $time, pwm_out, model_pwm());
      end
      if (frame_start !== e_fs) begin
        failures++;
        $display("FAIL cyc_frame_start t=%0t got %b expected %b", $time, frame_start, e_fs);
      end
      if (running !== m_run) begin
        failures++;
        $display("FAIL cyc_running t=%0t got %b expected %b", $time, running, m_run);
      end
      if (cfg_err !== e_err) begin
        failures++;
        $display("FAIL cyc_cfg_err t=%0t got %b expected %b", $time, cfg_err, e_err);
      end
      if (cfg_ready !== model_ready()) begin
        failures++;
        $display("FAIL cyc_cfg_ready t=%0t got %b expected %b", $time, cfg_ready, model_ready());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    drv_cnt = (drv_cnt + 1) % FRAME;
  endtask

  task automatic tick_to(input int n);
    while (drv_cnt != n) do_tick();
  endtask

  task automatic cfg_write(input int ch, input int w);
    cfg_valid = 1'b1;
    cfg_ch = 3'(ch);
    cfg_width = 10'(w);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pwm_at(input int n, input logic [3:0] exp);
    tick_to(n);
    check($sformatf("pwm_at_%0d", n), 32'(pwm_out), 32'(exp));
  endtask

  initial begin
    step();
    step();
    reset = 1'b1;
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    check("rst_cfg_err", 32'(cfg_err), 32'h0);

    // Frame A: default widths, mid-frame writes staged for frame B
    enable = 1'b1;
    drv_cnt = FRAME - 1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    drv_cnt = 0;
    check("a_frame_start", 32'(frame_start), 32'h1);
    check("a_running", 32'(running), 32'h1);
    check("a_pwm0", 32'(pwm_out), 32'h1);
    step();
    check("a_frame_start_clear", 32'(frame_start), 32'h0);
    pwm_at(299, 4'b0001);
    pwm_at(300, 4'b0000);
    pwm_at(500, 4'b0010);
    pwm_at(799, 4'b0010);
    pwm_at(800, 4'b0000);
    cfg_write(2, 250);
    cfg_write(0, 50);
    cfg_write(1, 900);
    cfg_write(5, 10);
    check("a_cfg_err_pulse", 32'(cfg_err), 32'h1);
    step();
    check("a_cfg_err_clear", 32'(cfg_err), 32'h0);
    pwm_at(1000, 4'b0100);
    pwm_at(1299, 4'b0100);
    pwm_at(1300, 4'b0000);

    // Write held across the wrap tick is deferred one cycle and lands in frame C
    tick_to(FRAME - 1);
    cfg_valid = 1'b1;
    cfg_ch = 3'd3;
    cfg_width = 10'd350;
    tick = 1'b1;
    #1;
    check("wrap_cfg_ready_low", 32'(cfg_ready), 32'h0);
    step();
    tick = 1'b0;
    drv_cnt = 0;
    #1;
    check("b_frame_start", 32'(frame_start), 32'h1);
    check("wrap_cfg_ready_high", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    step();

    // Frame B: clamped widths 200/400, ch2 250, ch3 still 300
    check("b_pwm0", 32'(pwm_out), 32'h1);
    pwm_at(199, 4'b0001);
    pwm_at(200, 4'b0000);
    pwm_at(899, 4'b0010);
    pwm_at(900, 4'b0000);
    pwm_at(1249, 4'b0100);
    pwm_at(1250, 4'b0000);
    pwm_at(1799, 4'b1000);
    pwm_at(1800, 4'b0000);
    tick_to(FRAME - 1);
    do_tick();

    // Frame C: disable mid-frame, pulses still complete, then idle
    pwm_at(600, 4'b0010);
    enable = 1'b0;
    pwm_at(899, 4'b0010);
    pwm_at(900, 4'b0000);
    pwm_at(1000, 4'b0100);
    pwm_at(1849, 4'b1000);
    pwm_at(1850, 4'b0000);
    tick_to(FRAME - 1);
    check("c_running_last", 32'(running), 32'h1);
    do_tick();
    check("c_idle_running", 32'(running), 32'h0);
    check("c_idle_pwm", 32'(pwm_out), 32'h0);
    for (int k = 0; k < 5; k++) do_tick();
    check("c_still_idle", 32'(running), 32'h0);

    // Frame D: restart, then reset while ch1 is high
    enable = 1'b1;
    drv_cnt = FRAME - 1;
    do_tick();
    check("d_running", 32'(running), 32'h1);
    pwm_at(520, 4'b0010);
    reset = 1'b0;
    step();
    check("d_rst_pwm", 32'(pwm_out), 32'h0);
    check("d_rst_running", 32'(running), 32'h0);
    check("d_rst_cfg_ready", 32'(cfg_ready), 32'h1);
    reset = 1'b1;
    step();

    // Restart after reset: widths are back to 300
    drv_cnt = FRAME - 1;
    do_tick();
    check("e_running", 32'(running), 32'h1);
    pwm_at(299, 4'b0001);
    pwm_at(300, 4'b0000);
    pwm_at(799, 4'b0010);
    pwm_at(800, 4'b0000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
